// File: rtl/id_pipe.sv
// Instruction decode stage: decodes a small MIPS-style logic subset, resolves operands
// through a forwarding network, detects load-use hazards and drives a registered ID->EX slot.
module id_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int FWD_N  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_inst,
  input  logic [DATA_W-1:0]         in_pc,
  output logic                      re1,
  output logic                      re2,
  output logic [REG_AW-1:0]         raddr1,
  output logic [REG_AW-1:0]         raddr2,
  input  logic [DATA_W-1:0]         rdata1,
  input  logic [DATA_W-1:0]         rdata2,
  input  logic [FWD_N-1:0]          fwd_we,
  input  logic [FWD_N*REG_AW-1:0]   fwd_addr,
  input  logic [FWD_N*DATA_W-1:0]   fwd_data,
  input  logic                      ex_load,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_aluop,
  output logic [DATA_W-1:0]         out_op1,
  output logic [DATA_W-1:0]         out_op2,
  output logic                      out_we,
  output logic [REG_AW-1:0]         out_waddr,
  output logic [DATA_W-1:0]         out_pc,
  output logic                      out_illegal,
  output logic [CNT_W-1:0]          stall_cnt
);

  logic [5:0]        opc, funct;
  logic [7:0]        aluop_d;
  logic              we_d, illegal_d;
  logic [REG_AW-1:0] dst_d, a0;
  logic [DATA_W-1:0] imm_d, op1_d, op2_d;
  logic              hazard, free;
  logic              unused_shamt;

  assign opc          = in_inst[31:26];
  assign funct        = in_inst[5:0];
  assign raddr1       = REG_AW'(in_inst[25:21]);
  assign raddr2       = REG_AW'(in_inst[20:16]);
  assign unused_shamt = ^in_inst[10:6];

  always_comb begin
    aluop_d   = 8'h00;
    re1       = 1'b0;
    re2       = 1'b0;
    we_d      = 1'b0;
    illegal_d = 1'b0;
    dst_d     = REG_AW'(in_inst[20:16]);
    imm_d     = DATA_W'(in_inst[15:0]);
    case (opc)
      6'h0C: begin aluop_d = 8'h24; re1 = 1'b1; we_d = 1'b1; end
      6'h0D: begin aluop_d = 8'h25; re1 = 1'b1; we_d = 1'b1; end
      6'h0E: begin aluop_d = 8'h26; re1 = 1'b1; we_d = 1'b1; end
      6'h0F: begin
        aluop_d = 8'h0F;
        we_d    = 1'b1;
        imm_d   = DATA_W'({in_inst[15:0], 16'h0000});
      end
      6'h00: begin
        if (funct >= 6'h24 && funct <= 6'h27) begin
          aluop_d = {2'b00, funct};
          re1     = 1'b1;
          re2     = 1'b1;
          we_d    = 1'b1;
          dst_d   = REG_AW'(in_inst[15:11]);
        end else begin
          illegal_d = 1'b1;
        end
      end
      default: illegal_d = 1'b1;
    endcase
  end

  // Lowest forwarding index is the youngest producer, so it is applied last and wins.
  function automatic logic [DATA_W-1:0] resolve(
    input logic                    en,
    input logic [REG_AW-1:0]       a,
    input logic [DATA_W-1:0]       rf,
    input logic [DATA_W-1:0]       dflt,
    input logic [FWD_N-1:0]        fw,
    input logic [FWD_N*REG_AW-1:0] fa,
    input logic [FWD_N*DATA_W-1:0] fd
  );
    logic [DATA_W-1:0] v;
    v = rf;
    for (int i = FWD_N - 1; i >= 0; i--)
      if (fw[i] && fa[i*REG_AW +: REG_AW] == a) v = fd[i*DATA_W +: DATA_W];
    if (a == '0) v = '0;
    if (!en) v = dflt;
    return v;
  endfunction

  always_comb begin
    op1_d = resolve(re1, raddr1, rdata1, '0,    fwd_we, fwd_addr, fwd_data);
    op2_d = resolve(re2, raddr2, rdata2, imm_d, fwd_we, fwd_addr, fwd_data);
  end

  assign a0     = fwd_addr[REG_AW-1:0];
  assign hazard = in_valid & ex_load & fwd_we[0] & (a0 != '0) &
                  ((re1 & (raddr1 == a0)) | (re2 & (raddr2 == a0)));
  assign free   = ~out_valid | out_ready;
  // A flush always consumes the input, even while stalled or back-pressured.
  assign in_ready = ~rst & (flush | (~hazard & free));

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_we      <= 1'b0;
      out_illegal <= 1'b0;
      out_aluop   <= 8'h00;
      out_op1     <= '0;
      out_op2     <= '0;
      out_waddr   <= '0;
      out_pc      <= '0;
      stall_cnt   <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
        out_we    <= 1'b0;
      end else if (free) begin
        out_valid   <= in_valid & ~hazard;
        out_we      <= in_valid & ~hazard & we_d & ~illegal_d;
        out_illegal <= illegal_d;
        out_aluop   <= aluop_d;
        out_op1     <= op1_d;
        out_op2     <= op2_d;
        out_waddr   <= dst_d;
        out_pc      <= in_pc;
      end
      if (hazard && !flush && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_pipe.sv
// Directed bench for id_pipe: a behavioural decode/forwarding model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_id_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, ex_load, flush, out_ready;
  logic [31:0] in_inst, in_pc, rdata1, rdata2;
  logic [1:0]  fwd_we;
  logic [9:0]  fwd_addr;
  logic [63:0] fwd_data;

  logic        in_ready, re1, re2, out_valid, out_we, out_illegal;
  logic [4:0]  raddr1, raddr2, out_waddr;
  logic [7:0]  out_aluop;
  logic [31:0] out_op1, out_op2, out_pc;
  logic [15:0] stall_cnt;

  logic        b_in_ready, b_re1, b_re2, b_out_valid, b_out_we, b_out_illegal;
  logic [4:0]  b_raddr1, b_raddr2, b_out_waddr;
  logic [7:0]  b_out_aluop;
  logic [31:0] b_out_op1, b_out_op2, b_out_pc;
  logic [1:0]  b_stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .fwd_we(fwd_we), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .ex_load(ex_load), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_aluop(out_aluop), .out_op1(out_op1), .out_op2(out_op2),
    .out_we(out_we), .out_waddr(out_waddr), .out_pc(out_pc), .out_illegal(out_illegal),
    .stall_cnt(stall_cnt)
  );

  id_pipe #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .re1(b_re1), .re2(b_re2), .raddr1(b_raddr1), .raddr2(b_raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .fwd_we(fwd_we), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .ex_load(ex_load), .flush(flush), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_aluop(b_out_aluop), .out_op1(b_out_op1),
    .out_op2(b_out_op2), .out_we(b_out_we), .out_waddr(b_out_waddr), .out_pc(b_out_pc),
    .out_illegal(b_out_illegal), .stall_cnt(b_stall_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        ok;
    logic [7:0]  op;
    logic        r1, r2, we;
    logic [4:0]  dst;
    logic [31:0] imm;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] i);
    dec_t d;
    logic [5:0] oc, fn;
    oc = i[31:26];
    fn = i[5:0];
    d.ok = 1'b1; d.op = 8'h00; d.r1 = 1'b0; d.r2 = 1'b0; d.we = 1'b1;
    d.dst = i[20:16]; d.imm = {16'h0, i[15:0]};
    if (oc >= 6'h0C && oc <= 6'h0E) begin
      d.op = 8'h18 + 8'(oc);   // 0x0C/0D/0E -> AND/OR/XOR codes 0x24/25/26
      d.r1 = 1'b1;
    end else if (oc == 6'h0F) begin
      d.op = 8'h0F;
      d.imm = {i[15:0], 16'h0};
    end else if (oc == 6'h00 && fn >= 6'h24 && fn <= 6'h27) begin
      d.op = 8'(fn);
      d.r1 = 1'b1; d.r2 = 1'b1;
      d.dst = i[15:11];
    end else begin
      d.ok = 1'b0; d.we = 1'b0;
    end
    return d;
  endfunction

  function automatic logic [31:0] opnd(input logic en, input logic [4:0] a,
                                       input logic [31:0] rf, input logic [31:0] dflt);
    if (!en) return dflt;
    if (a == 5'd0) return 32'h0;
    for (int i = 0; i < 2; i++)
      if (fwd_we[i] && fwd_addr[i*5 +: 5] == a) return fwd_data[i*32 +: 32];
    return rf;
  endfunction

  function automatic logic mhazard();
    dec_t d;
    logic [4:0] a0;
    d  = decode(in_inst);
    a0 = fwd_addr[4:0];
    return in_valid && ex_load && fwd_we[0] && a0 != 5'd0 &&
           ((d.r1 && in_inst[25:21] == a0) || (d.r2 && in_inst[20:16] == a0));
  endfunction

  logic        m_valid = 1'b0, m_we = 1'b0, m_ill = 1'b0;
  logic [7:0]  m_op = 8'h0;
  logic [31:0] m_op1 = 0, m_op2 = 0, m_pc = 0;
  logic [4:0]  m_waddr = 0;
  int          m_cnt = 0, m_cnt2 = 0;

  always @(posedge clk) begin
    dec_t d;
    logic hz;
    d  = decode(in_inst);
    hz = mhazard();
    if (rst) begin
      m_valid = 0; m_we = 0; m_ill = 0; m_op = 0; m_op1 = 0; m_op2 = 0;
      m_waddr = 0; m_pc = 0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      if (flush) begin
        m_valid = 0; m_we = 0;
      end else if (!m_valid || out_ready) begin
        m_valid = in_valid && !hz;
        m_we    = m_valid && d.we;
        m_ill   = !d.ok;
        m_op    = d.op;
        m_op1   = opnd(d.r1, in_inst[25:21], rdata1, 32'h0);
        m_op2   = opnd(d.r2, in_inst[20:16], rdata2, d.imm);
        m_waddr = d.dst;
        m_pc    = in_pc;
      end
      if (hz && !flush) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  end

  always @(negedge clk) begin
    dec_t d;
    d = decode(in_inst);
    chk("in_ready", in_ready, !rst && (flush || (!mhazard() && (!m_valid || out_ready))));
    chk("re1", re1, d.r1);
    chk("re2", re2, d.r2);
    chk("raddr1", raddr1, in_inst[25:21]);
    chk("out_valid", out_valid, m_valid);
    chk("out_we", out_we, m_we);
    chk("stall_cnt", stall_cnt, m_cnt);
    chk("stall_cnt2", b_stall_cnt, m_cnt2);
    chk("out_valid2", b_out_valid, m_valid);
    if (m_valid) begin
      chk("out_illegal", out_illegal, m_ill);
      chk("out_aluop", out_aluop, m_op);
      chk("out_pc", out_pc, m_pc);
      if (!m_ill) begin
        chk("out_op1", out_op1, m_op1);
        chk("out_op2", out_op2, m_op2);
        chk("out_waddr", out_waddr, m_waddr);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; in_valid = 0; in_inst = 0; in_pc = 0; rdata1 = 0; rdata2 = 0;
    fwd_we = 0; fwd_addr = 0; fwd_data = 0; ex_load = 0; flush = 0; out_ready = 1;
    step(); step();
    chk("rst_valid", out_valid, 0);
    chk("rst_we", out_we, 0);
    chk("rst_ill", out_illegal, 0);
    chk("rst_aluop", out_aluop, 0);
    chk("rst_op1", out_op1, 0);
    chk("rst_op2", out_op2, 0);
    chk("rst_waddr", out_waddr, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_ready", in_ready, 0);
    rst = 0;

    // ORI $1,$0,0x1100
    in_valid = 1; in_inst = {6'h0D, 5'd0, 5'd1, 16'h1100}; in_pc = 32'h100;
    step();
    chk("ori_valid", out_valid, 1);
    chk("ori_aluop", out_aluop, 8'h25);
    chk("ori_op1", out_op1, 0);
    chk("ori_op2", out_op2, 32'h1100);
    chk("ori_we", out_we, 1);
    chk("ori_waddr", out_waddr, 1);

    // OR $3,$1,$2 with both sources forwarding $1
    in_inst = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h25}; in_pc = 32'h104;
    fwd_we = 2'b11; fwd_addr = {5'd1, 5'd1}; fwd_data = {32'h5555, 32'hAAAA0000};
    rdata2 = 32'h7;
    step();
    chk("or_op1", out_op1, 32'hAAAA0000);
    chk("or_op2", out_op2, 32'h7);
    chk("or_waddr", out_waddr, 3);

    // ANDI $5,$4,0xFF behind a load to $4
    in_inst = {6'h0C, 5'd4, 5'd5, 16'h00FF}; in_pc = 32'h108;
    fwd_we = 2'b01; fwd_addr = {5'd0, 5'd4}; fwd_data = 64'h0; ex_load = 1;
    rdata1 = 32'h1234;
    #1 chk("ld_ready", in_ready, 0);
    step();
    chk("ld_bubble", out_valid, 0);
    chk("ld_cnt", stall_cnt, 1);
    ex_load = 0; fwd_we = 2'b00;
    step();
    chk("ld_issue", out_valid, 1);
    chk("ld_aluop", out_aluop, 8'h24);
    chk("ld_op1", out_op1, 32'h1234);
    chk("ld_op2", out_op2, 32'hFF);

    // Back-pressure for 3 cycles with XORI $6,$2,0xF0F0 waiting
    in_inst = {6'h0E, 5'd2, 5'd6, 16'hF0F0}; in_pc = 32'h10C;
    rdata1 = 32'h0F0F0F0F; out_ready = 0;
    repeat (3) begin
      step();
      chk("bp_hold", out_aluop, 8'h24);
      chk("bp_pc", out_pc, 32'h108);
      chk("bp_ready", in_ready, 0);
    end
    out_ready = 1;
    #1 chk("bp_release", in_ready, 1);
    step();
    chk("bp_aluop", out_aluop, 8'h26);
    chk("bp_op1", out_op1, 32'h0F0F0F0F);

    // flush together with a hazard on $2
    ex_load = 1; fwd_we = 2'b01; fwd_addr = {5'd0, 5'd2}; flush = 1;
    #1 chk("fl_ready", in_ready, 1);
    step();
    chk("fl_valid", out_valid, 0);
    chk("fl_cnt", stall_cnt, 1);
    flush = 0; ex_load = 0; fwd_we = 0;

    // illegal opcode and illegal funct
    in_inst = {6'h3F, 26'h0}; in_pc = 32'h110;
    step();
    chk("ill_valid", out_valid, 1);
    chk("ill_flag", out_illegal, 1);
    chk("ill_we", out_we, 0);
    chk("ill_aluop", out_aluop, 8'h00);
    in_inst = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
    step();
    chk("illf_flag", out_illegal, 1);

    // LUI $7,0xBEEF
    in_inst = {6'h0F, 5'd9, 5'd7, 16'hBEEF};
    step();
    chk("lui_op1", out_op1, 0);
    chk("lui_op2", out_op2, 32'hBEEF0000);
    chk("lui_aluop", out_aluop, 8'h0F);

    // XOR $4,$0,$5: $0 ignores forwarding, $5 comes from the older source
    in_inst = {6'h00, 5'd0, 5'd5, 5'd4, 5'd0, 6'h26};
    fwd_we = 2'b11; fwd_addr = {5'd5, 5'd0}; fwd_data = {32'h77, 32'hDEAD};
    step();
    chk("x0_op1", out_op1, 0);
    chk("x0_op2", out_op2, 32'h77);
    fwd_we = 0;

    // NOR $8,$9,$10 from the register file, then an idle cycle
    in_inst = {6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h27}; rdata1 = 32'hC0; rdata2 = 32'h0C;
    step();
    chk("nor_aluop", out_aluop, 8'h27);
    chk("nor_op2", out_op2, 32'h0C);
    in_valid = 0;
    step();
    chk("idle_valid", out_valid, 0);

    // five stall cycles: narrow counter saturates
    in_valid = 1; in_inst = {6'h0C, 5'd4, 5'd5, 16'h00FF};
    ex_load = 1; fwd_we = 2'b01; fwd_addr = {5'd0, 5'd4};
    repeat (5) step();
    chk("sat_cnt2", b_stall_cnt, 3);
    chk("sat_cnt", stall_cnt, 6);
    rst = 1;
    #1 chk("rst_stall_ready", in_ready, 0);
    step();
    chk("rst_cnt_clr", stall_cnt, 0);
    chk("rst_cnt2_clr", b_stall_cnt, 0);
    chk("rst_drop", out_valid, 0);
    rst = 0; ex_load = 0; fwd_we = 0;
    step();
    chk("post_valid", out_valid, 1);
    in_valid = 0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
